// File: rtl/corner_track_ctrl.sv
// corner_track_ctrl: frame-level sequencer that admits whole aligned frames into the corner finder and presents its results with a lock flag
module corner_track_ctrl #(
   parameter int H_ACT       = 800,
   parameter int V_ACT       = 600,
   parameter int SKIP        = 0,
   parameter int LOCK_FRAMES = 4,
   parameter int LOCK_TOL    = 4,
   parameter int RES_TIMEOUT = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_freeze,
   input  logic        i_sof,
   input  logic        i_pix_valid,
   input  logic        i_pix_data,
   output logic        o_cf_rst_n,
   output logic        o_cf_valid,
   output logic        o_cf_data,
   input  logic        i_cf_valid,
   input  logic        i_cf_success,
   input  logic [19:0] i_cf_ul,
   input  logic [19:0] i_cf_ur,
   input  logic [19:0] i_cf_dl,
   input  logic [19:0] i_cf_dr,
   output logic        o_crn_valid,
   input  logic        i_crn_ready,
   output logic [19:0] o_crn_ul,
   output logic [19:0] o_crn_ur,
   output logic [19:0] o_crn_dl,
   output logic [19:0] o_crn_dr,
   output logic        o_crn_success,
   output logic        o_locked,
   output logic        o_busy,
   output logic [7:0]  o_err_cnt
);
   localparam int FRAME = H_ACT * V_ACT;
   localparam int BW = $clog2(FRAME + 1);
   localparam int SW = SKIP > 0 ? $clog2(SKIP + 1) : 1;
   localparam int TW = $clog2(RES_TIMEOUT + 1);
   localparam int LW = $clog2(LOCK_FRAMES + 1);
   localparam logic signed [10:0] TOL = 11'(LOCK_TOL);
   localparam logic [19:0] UL0 = 20'd0;
   localparam logic [19:0] UR0 = {10'd0, 10'(H_ACT - 1)};
   localparam logic [19:0] DL0 = {10'(V_ACT - 1), 10'd0};
   localparam logic [19:0] DR0 = {10'(V_ACT - 1), 10'(H_ACT - 1)};

   typedef enum logic [2:0] {IDLE, ARM, RUN, WAIT_RES, RESYNC, PRESENT} state_t;

   state_t          state;
   logic [BW-1:0]   beat_cnt;
   logic [SW-1:0]   skip_cnt;
   logic [TW-1:0]   to_cnt;
   logic [LW-1:0]   stable_cnt;
   logic [LW-1:0]   stable_nxt;
   logic            rs_cnt;
   logic            rst_n_q;
   logic            stable;
   logic            sof_beat;
   logic [7:0]      err_nxt;

   function automatic logic near(input logic [9:0] a, input logic [9:0] b);
      logic signed [10:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return (d <= TOL) && (d >= -TOL);
   endfunction

   function automatic logic close(input logic [19:0] a, input logic [19:0] b);
      return near(a[19:10], b[19:10]) && near(a[9:0], b[9:0]);
   endfunction

   assign sof_beat   = i_sof & i_pix_valid;
   assign err_nxt    = o_err_cnt + {7'd0, o_err_cnt != 8'hFF};
   assign o_busy     = state != IDLE;
   assign o_cf_rst_n = rst_n_q & ~i_rst;

   // Stability of the incoming result against the corners currently held, and the resulting stable count
   always_comb begin
      stable = i_cf_success && close(i_cf_ul, o_crn_ul) && close(i_cf_ur, o_crn_ur)
               && close(i_cf_dl, o_crn_dl) && close(i_cf_dr, o_crn_dr);
      stable_nxt = !stable ? '0 : (stable_cnt == LW'(LOCK_FRAMES)) ? stable_cnt : stable_cnt + LW'(1);
   end

   // Frame sequencer: gates pixels into the finder, resynchronises it on errors and presents results
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         rst_n_q       <= 1'b1;
         o_cf_valid    <= 1'b0;
         o_cf_data     <= 1'b0;
         o_crn_valid   <= 1'b0;
         o_crn_success <= 1'b0;
         o_locked      <= 1'b0;
         o_err_cnt     <= 8'd0;
         o_crn_ul      <= UL0;
         o_crn_ur      <= UR0;
         o_crn_dl      <= DL0;
         o_crn_dr      <= DR0;
         beat_cnt      <= '0;
         skip_cnt      <= '0;
         to_cnt        <= '0;
         stable_cnt    <= '0;
         rs_cnt        <= 1'b0;
      end else begin
         o_cf_valid <= 1'b0;
         o_cf_data  <= 1'b0;
         case (state)
            IDLE: if (i_enable) state <= ARM;
            ARM: begin
               if (!i_enable) begin
                  state <= IDLE;
               end else if (sof_beat) begin
                  if (skip_cnt == '0) begin
                     o_cf_valid <= 1'b1;
                     o_cf_data  <= i_pix_data;
                     beat_cnt   <= BW'(1);
                     skip_cnt   <= SW'(SKIP);
                     to_cnt     <= '0;
                     state      <= (FRAME == 1) ? WAIT_RES : RUN;
                  end else begin
                     skip_cnt <= skip_cnt - SW'(1);
                  end
               end
            end
            RUN: begin
               if (i_pix_valid) begin
                  if (i_sof) begin
                     state     <= RESYNC;
                     rst_n_q   <= 1'b0;
                     rs_cnt    <= 1'b0;
                     o_err_cnt <= err_nxt;
                  end else begin
                     o_cf_valid <= 1'b1;
                     o_cf_data  <= i_pix_data;
                     beat_cnt   <= beat_cnt + BW'(1);
                     if (beat_cnt == BW'(FRAME - 1)) begin
                        state  <= WAIT_RES;
                        to_cnt <= '0;
                     end
                  end
               end
            end
            WAIT_RES: begin
               if (i_cf_valid) begin
                  if (i_freeze) begin
                     state <= ARM;
                  end else begin
                     o_crn_ul      <= i_cf_ul;
                     o_crn_ur      <= i_cf_ur;
                     o_crn_dl      <= i_cf_dl;
                     o_crn_dr      <= i_cf_dr;
                     o_crn_success <= i_cf_success;
                     stable_cnt    <= stable_nxt;
                     o_locked      <= stable_nxt == LW'(LOCK_FRAMES);
                     o_crn_valid   <= 1'b1;
                     state         <= PRESENT;
                  end
               end else if (to_cnt == TW'(RES_TIMEOUT - 1)) begin
                  state     <= RESYNC;
                  rst_n_q   <= 1'b0;
                  rs_cnt    <= 1'b0;
                  o_err_cnt <= err_nxt;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            RESYNC: begin
               beat_cnt <= '0;
               if (rs_cnt) begin
                  rst_n_q <= 1'b1;
                  state   <= ARM;
               end else begin
                  rs_cnt <= 1'b1;
               end
            end
            PRESENT: begin
               if (i_crn_ready) begin
                  o_crn_valid <= 1'b0;
                  state       <= ARM;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/corner_track_ctrl.md
Name: corner_track_ctrl

Overview:
- Frame-level sequencer for the corner-finder datapath. Sits between the binarised pixel stream and the corner finder.
- Admits only whole, aligned frames into the finder and decimates frames by a programmable skip count.
- Resynchronises the finder on malformed frames or a missing result, and hands each result to the downstream perspective-transform stage over a valid/ready handshake with a lock (stability) flag.

Parameters:
- H_ACT, 800, active pixels per line.
- V_ACT, 600, active lines per frame; finder frame = H_ACT*V_ACT valid beats.
- SKIP, 0, frames ignored between processed frames (process 1 of SKIP+1).
- LOCK_FRAMES, 4, consecutive stable results required for o_locked.
- LOCK_TOL, 4, max per-coordinate change (pixels) counted as stable.
- RES_TIMEOUT, 8, cycles allowed between last forwarded beat and finder result.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock, asynchronous, active-high.
- i_enable  in  1  tracking enable.
- i_freeze  in  1  discard new results; outputs hold last presented corners.
- i_sof  in  1  start of frame; qualified by i_pix_valid on pixel (0,0).
- i_pix_valid  in  1  pixel beat valid.
- i_pix_data  in  1  binary mask pixel.
- o_cf_rst_n  out  1  active-low reset to corner finder.
- o_cf_valid  out  1  gated pixel valid to finder.
- o_cf_data  out  1  gated pixel to finder.
- i_cf_valid  in  1  finder result strobe.
- i_cf_success  in  1  finder success flag.
- i_cf_ul, i_cf_ur, i_cf_dl, i_cf_dr  in  20 each  finder corners {row[19:10], col[9:0]}.
- o_crn_valid  out  1  result valid to downstream.
- i_crn_ready  in  1  downstream accept.
- o_crn_ul, o_crn_ur, o_crn_dl, o_crn_dr  out  20 each  held corners.
- o_crn_success  out  1  held success flag.
- o_locked  out  1  corners stable.
- o_busy  out  1  high in any state but IDLE.
- o_err_cnt  out  8  saturating resync count.

Behaviour:
- Reset values (i_rst high, async):
  - State IDLE; o_cf_rst_n=0 while i_rst high, 1 after release.
  - o_cf_valid=0, o_cf_data=0, o_crn_valid=0, o_crn_success=0, o_locked=0, o_err_cnt=0.
  - Corners UL={0,0}, UR={0,799}, DL={599,0}, DR={599,799}.
  - Beat, skip, timeout and stable counters all 0.
- o_cf_valid/o_cf_data are registered: 1-cycle latency from i_pix_valid/i_pix_data. Gated high only for beats admitted in ARM (start beat) or RUN.
- IDLE: i_enable=1 -> ARM.
- ARM:
  - i_enable=0 -> IDLE.
  - On i_sof&i_pix_valid with skip_cnt==0: forward the beat, beat_cnt=1, reload skip_cnt=SKIP -> RUN.
  - On i_sof&i_pix_valid with skip_cnt!=0: decrement skip_cnt, stay in ARM.
- RUN:
  - Forward every valid beat; beat_cnt increments per beat.
  - Forwarding beat H_ACT*V_ACT -> WAIT_RES, clear timeout counter.
  - i_sof&i_pix_valid before the full count (short frame) -> RESYNC, o_err_cnt++ (saturate 255). That beat is not forwarded.
  - i_enable is ignored in RUN; the frame completes.
- WAIT_RES:
  - i_cf_valid -> capture result.
    - i_freeze=1: discard -> ARM.
    - Else load o_crn_* and update the stable counter -> PRESENT.
  - Timeout counter reaching RES_TIMEOUT without i_cf_valid -> RESYNC, err++.
- RESYNC: o_cf_rst_n=0 for exactly 2 cycles, beat_cnt=0 -> ARM. skip_cnt is not reloaded.
- PRESENT:
  - o_crn_valid=1; o_crn_* stable until i_crn_ready sampled high.
  - Cycle after the handshake: o_crn_valid=0 -> ARM.
  - Frames arriving meanwhile are not forwarded; the next i_sof in ARM is used.
- Lock logic, evaluated on capture when not frozen:
  - stable if i_cf_success=1 and |new-old| <= LOCK_TOL for all 8 row/col fields vs the currently held corners. Use 11-bit signed differences.
  - stable: stable_cnt++ saturating at LOCK_FRAMES; otherwise stable_cnt=0.
  - o_locked = (stable_cnt==LOCK_FRAMES), registered.
- Simultaneous events:
  - i_cf_valid and timeout expiry in the same cycle: the result wins.
  - i_sof on the final expected beat of RUN: treated as short frame (RESYNC).
- i_rst mid-frame forces IDLE and holds the finder in reset; no partial result is presented.

Test Plan:
- SKIP=0, two full 800x600 frames with a square blob, finder result 2 cycles after last beat, i_crn_ready=1 -> exactly 480000 o_cf_valid beats per frame; o_crn_valid 1 cycle per frame; corners match i_cf_*.
- i_sof at beat 1000 of RUN -> o_cf_rst_n low 2 cycles; o_err_cnt=1; next i_sof frame processed normally.
- No i_cf_valid after full frame, RES_TIMEOUT=8 -> RESYNC entered 8 cycles after last beat; o_err_cnt increments.
- i_crn_ready held low 50 cycles in PRESENT -> o_crn_valid and corners constant; following frame not forwarded; ARM on the next i_sof after ready.
- SKIP=2, 9 frames -> frames 1, 4, 7 forwarded; other frames produce no o_cf_valid.
- Stable corners (±3 px) for 5 frames -> o_locked rises on the 4th stable capture; a 10 px jump or i_cf_success=0 -> o_locked=0. i_freeze=1 -> outputs and o_locked unchanged.
